// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode, register-file, writeback and execute signals of the operand fetch stage.
// master = surrounding pipeline / register file, slave = operand_fetch.
interface operand_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs;
  logic [ADDR_W-1:0] in_rt;
  logic [ADDR_W-1:0] in_rd;
  logic              in_we;
  logic [ADDR_W-1:0] rf_addra;
  logic [ADDR_W-1:0] rf_addrb;
  logic [DATA_W-1:0] rf_dataa;
  logic [DATA_W-1:0] rf_datab;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [ADDR_W-1:0] out_rd;
  logic              out_we;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_we,
    output rf_dataa, rf_datab,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, rf_addra, rf_addrb,
    input  out_valid, out_a, out_b, out_rd, out_we
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_we,
    input  rf_dataa, rf_datab,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, rf_addra, rf_addrb,
    output out_valid, out_a, out_b, out_rd, out_we
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute operand fetch stage in front of a registered-read register file.
// Per-register scoreboard blocks RAW/WAW hazards; register 0 always reads as zero.
// Define OPERAND_FETCH_BYPASS_EN to capture a same-edge writeback into bypass registers instead
// of stalling the consumer for one cycle.
module operand_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic           clock,
  input  logic           reset,
  operand_fetch_if.slave bus
);
  localparam int unsigned NREGS = 2 ** ADDR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NREGS-1:0]  sb_q, sb_d;
  logic [ADDR_W-1:0] rs_q, rs_d;
  logic [ADDR_W-1:0] rt_q, rt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              we_q, we_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [ADDR_W-1:0] out_rd_q, out_rd_d;
  logic              out_we_q, out_we_d;

  logic [NREGS-1:0]  clr_mask_c;
  logic [NREGS-1:0]  sb_live_c;
  logic              raw_a_c, raw_b_c, waw_c, wb_hit_c;
  logic              hazard_c, free_c, ready_c, issue_c;
  logic [DATA_W-1:0] src_a_c, src_b_c;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic              byp_a_q, byp_a_d;
  logic              byp_b_q, byp_b_d;
  logic [DATA_W-1:0] bypd_a_q, bypd_a_d;
  logic [DATA_W-1:0] bypd_b_q, bypd_b_d;
`endif

  // Scoreboard bit released by this cycle's writeback, so it no longer blocks issue
  always_comb begin
    clr_mask_c = '0;
    if (bus.wb_en && (bus.wb_addr != '0)) clr_mask_c[bus.wb_addr] = 1'b1;
  end

  assign sb_live_c = sb_q & ~clr_mask_c;

  assign raw_a_c = sb_live_c[bus.in_rs] && (bus.in_rs != '0);
  assign raw_b_c = sb_live_c[bus.in_rt] && (bus.in_rt != '0);
  assign waw_c   = bus.in_we && sb_live_c[bus.in_rd] && (bus.in_rd != '0);

`ifdef OPERAND_FETCH_BYPASS_EN
  assign wb_hit_c = 1'b0;
  assign src_a_c  = byp_a_q ? bypd_a_q : bus.rf_dataa;
  assign src_b_c  = byp_b_q ? bypd_b_q : bus.rf_datab;
`else
  // RF returns pre-write data on a same-edge read/write, so wait one cycle instead
  assign wb_hit_c = bus.wb_en &&
                    (((bus.wb_addr == bus.in_rs) && (bus.in_rs != '0)) ||
                     ((bus.wb_addr == bus.in_rt) && (bus.in_rt != '0)));
  assign src_a_c  = bus.rf_dataa;
  assign src_b_c  = bus.rf_datab;
`endif

  assign hazard_c = bus.in_valid && (raw_a_c || raw_b_c || waw_c || wb_hit_c);
  assign free_c   = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
  assign ready_c  = free_c && !hazard_c;
  assign issue_c  = bus.in_valid && ready_c;

  assign bus.in_ready  = ready_c;
  assign bus.rf_addra  = (state_q == READ) ? rs_q : bus.in_rs;
  assign bus.rf_addrb  = (state_q == READ) ? rt_q : bus.in_rt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_we    = out_we_q;

  // Next state: issue latch, scoreboard update and operand capture
  always_comb begin
    state_d     = state_q;
    sb_d        = sb_live_c;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    we_d        = we_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_rd_d    = out_rd_q;
    out_we_d    = out_we_q;
`ifdef OPERAND_FETCH_BYPASS_EN
    byp_a_d     = byp_a_q;
    byp_b_d     = byp_b_q;
    bypd_a_d    = bypd_a_q;
    bypd_b_d    = bypd_b_q;
`endif

    if (issue_c) begin
      rs_d = bus.in_rs;
      rt_d = bus.in_rt;
      rd_d = bus.in_rd;
      we_d = bus.in_we;
      // Set after clear so a same-edge set/clear on one register leaves it pending
      if (bus.in_we && (bus.in_rd != '0)) sb_d[bus.in_rd] = 1'b1;
`ifdef OPERAND_FETCH_BYPASS_EN
      byp_a_d  = bus.wb_en && (bus.wb_addr == bus.in_rs) && (bus.in_rs != '0);
      byp_b_d  = bus.wb_en && (bus.wb_addr == bus.in_rt) && (bus.in_rt != '0);
      bypd_a_d = bus.wb_data;
      bypd_b_d = bus.wb_data;
`endif
    end

    case (state_q)
      IDLE: begin
        if (issue_c) state_d = READ;
      end
      READ: begin
        state_d     = HOLD;
        out_valid_d = 1'b1;
        out_a_d     = (rs_q == '0) ? '0 : src_a_c;
        out_b_d     = (rt_q == '0) ? '0 : src_b_c;
        out_rd_d    = rd_q;
        out_we_d    = we_q;
      end
      HOLD: begin
        if (issue_c) begin
          state_d     = READ;
          out_valid_d = 1'b0;
        end else if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, scoreboard and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sb_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_rd_q    <= out_rd_d;
      out_we_q    <= out_we_d;
    end
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  // Same-edge writeback bypass registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byp_a_q  <= 1'b0;
      byp_b_q  <= 1'b0;
      bypd_a_q <= '0;
      bypd_b_q <= '0;
    end else begin
      byp_a_q  <= byp_a_d;
      byp_b_q  <= byp_b_d;
      bypd_a_q <= bypd_a_d;
      bypd_b_q <= bypd_b_d;
    end
  end
`endif
endmodule
